// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source for the video mixer.
// Divides clk_vid down to a pixel enable and walks a pixel counter across
// the frame. Sync, blanking, coordinates and frame_start are registered on
// each pixel tick from the pre-edge counter position. A consumer that
// samples on ce_pix therefore sees one coherent pixel.
// Optional colour-bar test pattern on R/G/B: define VIDEO_TESTPAT_EN.
// Without that macro, R/G/B are tied to zero.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CE_DIV   = 4
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        enable,
  output logic        ce_pix,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST_C = 4'(CE_DIV - 1);
  localparam logic [11:0] H_LAST_C   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST_C   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_C    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_C    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG_C   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG_C   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_C   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  div_r;
  logic [11:0] hc_r;
  logic [11:0] vc_r;
  logic        tick_s;
  logic        hc_last_s;
  logic        vc_last_s;

  // Pixel tick and end-of-line / end-of-frame detection
  always_comb begin
    tick_s    = enable && (div_r == DIV_LAST_C);
    hc_last_s = (hc_r == H_LAST_C);
    vc_last_s = (vc_r == V_LAST_C);
  end

  // Clock divider and raster position counters; all hold while enable is low
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      div_r <= 4'd0;
      hc_r  <= 12'd0;
      vc_r  <= 12'd0;
    end else if (enable) begin
      if (tick_s) begin
        div_r <= 4'd0;
        if (hc_last_s) begin
          hc_r <= 12'd0;
          if (vc_last_s) begin
            vc_r <= 12'd0;
          end else begin
            vc_r <= vc_r + 12'd1;
          end
        end else begin
          hc_r <= hc_r + 12'd1;
        end
      end else begin
        div_r <= div_r + 4'd1;
      end
    end else begin
      div_r <= div_r;
    end
  end

  // Registered timing outputs, decoded from the pre-edge position on each tick
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      ce_pix      <= 1'b0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      HBlank      <= 1'b1;
      VBlank      <= 1'b1;
      x           <= 12'd0;
      y           <= 12'd0;
      frame_start <= 1'b0;
    end else begin
      ce_pix <= tick_s;
      if (tick_s) begin
        x           <= hc_r;
        y           <= vc_r;
        HBlank      <= (hc_r >= H_ACT_C);
        VBlank      <= (vc_r >= V_ACT_C);
        HSync       <= (hc_r >= HS_BEG_C) && (hc_r < HS_END_C);
        VSync       <= (vc_r >= VS_BEG_C) && (vc_r < VS_END_C);
        frame_start <= (hc_r == 12'd0) && (vc_r == 12'd0);
      end
    end
  end

`ifdef VIDEO_TESTPAT_EN
  // Bar width; H_ACTIVE >= 8 keeps this at least one pixel
  localparam int          BAR_W      = H_ACTIVE >> 3;
  localparam logic [11:0] BAR_LAST_C = 12'(BAR_W - 1);

  logic [11:0] bar_px_r;
  logic [2:0]  bar_idx_r;
  logic        active_s;

  // Current pixel lies in the visible area
  always_comb begin
    active_s = (hc_r < H_ACT_C) && (vc_r < V_ACT_C);
  end

  // Bar index tracks hc incrementally; saturates at 7 so the last bar takes the remainder
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      bar_px_r  <= 12'd0;
      bar_idx_r <= 3'd0;
    end else if (tick_s) begin
      if (hc_last_s) begin
        bar_px_r  <= 12'd0;
        bar_idx_r <= 3'd0;
      end else if (bar_px_r == BAR_LAST_C) begin
        bar_px_r  <= 12'd0;
        bar_idx_r <= (bar_idx_r == 3'd7) ? 3'd7 : bar_idx_r + 3'd1;
      end else begin
        bar_px_r <= bar_px_r + 12'd1;
      end
    end
  end

  // Colour-bar output registered alongside x; black during blanking
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      R <= 8'h00;
      G <= 8'h00;
      B <= 8'h00;
    end else if (tick_s) begin
      if (active_s) begin
        G <= {8{~bar_idx_r[2]}};
        R <= {8{~bar_idx_r[1]}};
        B <= {8{~bar_idx_r[0]}};
      end else begin
        R <= 8'h00;
        G <= 8'h00;
        B <= 8'h00;
      end
    end
  end
`else
  assign R = 8'h00;
  assign G = 8'h00;
  assign B = 8'h00;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster at CE_DIV=2.
// Expected pixel for clock k after reset release: pixel p = k/2-1 (k>=2),
// with ce_pix high on even k; geometry decode is derived from p.
module tb_video_timing_gen;

  logic        clk_vid = 1'b0;
  logic        reset;
  logic        enable;
  logic        ce_pix;
  logic        HSync;
  logic        VSync;
  logic        HBlank;
  logic        VBlank;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;

  int checks   = 0;
  int failures = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk_vid = ~clk_vid;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CE_DIV(2)
  ) dut (
    .clk_vid(clk_vid), .reset(reset), .enable(enable), .ce_pix(ce_pix),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .x(x), .y(y), .frame_start(frame_start), .R(R), .G(G), .B(B)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // p < 0 means reset values are expected
  task automatic check_pixel(input string tag, input int p, input logic ce_exp);
    int ex, ey;
    logic hb, vb, hs, vs, fs;
    logic [23:0] rgb;
    ex  = (p < 0) ? 0 : p % 16;
    ey  = (p < 0) ? 0 : (p / 16) % 8;
    hb  = (p < 0) ? 1'b1 : (ex >= 8);
    vb  = (p < 0) ? 1'b1 : (ey >= 4);
    hs  = (p >= 0) && (ex >= 10) && (ex <= 12);
    vs  = (p >= 0) && (ey >= 5) && (ey <= 6);
    fs  = (p >= 0) && (ex == 0) && (ey == 0);
    rgb = 24'h000000;
`ifdef VIDEO_TESTPAT_EN
    if ((p >= 0) && (ex < 8) && (ey < 4)) rgb = bars[ex];
`endif
    check({tag, "/ce_pix"}, 32'(ce_pix), 32'(ce_exp));
    check({tag, "/x"},      32'(x),      32'(ex));
    check({tag, "/y"},      32'(y),      32'(ey));
    check({tag, "/HBlank"}, 32'(HBlank), 32'(hb));
    check({tag, "/VBlank"}, 32'(VBlank), 32'(vb));
    check({tag, "/HSync"},  32'(HSync),  32'(hs));
    check({tag, "/VSync"},  32'(VSync),  32'(vs));
    check({tag, "/RGB"},    32'({R, G, B}), 32'(rgb));
    if (ce_exp || (p < 0)) check({tag, "/frame_start"}, 32'(frame_start), 32'(fs));
  endtask

  // Walk nclk clocks from reset release against the pixel-index model
  task automatic run_from_release(input string tag, input int nclk);
    logic prev_vs;
    prev_vs = VSync;
    for (int k = 1; k <= nclk; k++) begin
      @(negedge clk_vid);
      check_pixel(tag, (k < 2) ? -1 : (k / 2) - 1, (k >= 2) && (k % 2 == 0));
      if (VSync !== prev_vs) check({tag, "/vsync_edge_x"}, 32'(x), 32'd0);
      prev_vs = VSync;
    end
  endtask

  initial begin
    logic found;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk_vid);
    check_pixel("reset", -1, 1'b0);

    // Release: full frame plus wrap into the next frame, ending on x=5, y=0
    reset = 1'b0;
    run_from_release("run1", 268);
    check("at_x5", 32'(x), 32'd5);

    // Freeze for 7 clocks mid-line
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_vid);
      check_pixel("enable_low", 133, 1'b0);
    end
    enable = 1'b1;
    @(negedge clk_vid);
    check_pixel("reenable_0", 133, 1'b0);
    @(negedge clk_vid);
    check_pixel("reenable_1", 134, 1'b1);

    // Run to pixel (11,6) where both syncs are active
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_vid);
      if (ce_pix === 1'b1 && x === 12'd11 && y === 12'd6) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_x11_y6", 32'(found), 32'd1);
    check("pre_reset_HSync", 32'(HSync), 32'd1);
    check("pre_reset_VSync", 32'(VSync), 32'd1);

    // Mid-frame reset with enable still high
    reset = 1'b1;
    @(negedge clk_vid);
    check_pixel("mid_reset", -1, 1'b0);
    reset = 1'b0;
    run_from_release("run2", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
